univ_shift_reg: RTL and testbench
=================================

# univ_shift_reg

Parametrised universal shift register. It is the successor to the team's fixed 4-bit serial-in shift register. It adds configurable width, bidirectional shift, rotate, parallel load, synchronous clear, clock enable and a saturating shift counter with a `full` flag. It sits between serial bit sources (test pattern generators, serial receivers) and parallel consumers, or the reverse, as a serializer.

## Interface

Parameters:
- `W`, default 4: register width in bits. Legal range is W ≥ 2.
- `CW`, default `$clog2(W+1)`: width of the shift counter. Derived; do not override.

Ports:
- `ck`, input, 1 bit: clock. Rising edge active.
- `res_n`, input, 1 bit: reset. Asynchronous, active-low.
- `en`, input, 1 bit: clock enable. When 0, all state holds.
- `mode`, input, 3 bits: operation select. Encoding is listed under Operation.
- `sin`, input, 1 bit: serial data in.
- `pin`, input, W bits: parallel load data.
- `q`, output, W bits: register contents.
- `sout_l`, output, 1 bit: equals `q[W-1]`. Serial out for left shift.
- `sout_r`, output, 1 bit: equals `q[0]`. Serial out for right shift.
- `cnt`, output, CW bits: number of counted shifts since the last load, clear or reset. Saturates at W.
- `full`, output, 1 bit: 1 when `cnt == W`.

## Operation

Mode encoding, applied only when `en=1`:
- 0 HOLD: `q`, `cnt` and `full` unchanged.
- 1 SHL: `q <= {q[W-2:0], sin}`. Counted shift.
- 2 SHR: `q <= {sin, q[W-1:1]}`. Counted shift.
- 3 LOAD: `q <= pin`. `cnt <= 0`.
- 4 ROTL: `q <= {q[W-2:0], q[W-1]}`. `cnt` unchanged.
- 5 ROTR: `q <= {q[0], q[W-1:1]}`. `cnt` unchanged.
- 6 CLR: `q <= 0`. `cnt <= 0`.
- 7: reserved. Behaves as HOLD.

Counter rules:
- A counted shift increments `cnt` by 1, saturating at W. No wrap to 0.
- The shift itself still occurs after saturation.
- `full` is registered. It is set in the same cycle that `cnt` becomes W and cleared by LOAD, CLR or reset.
- Rotations never change `cnt` or `full`.

Other behaviour:
- `en=0`: all registers hold regardless of `mode`, `sin` and `pin`.
- `sout_l` and `sout_r` are pure wires from `q`, with no extra logic. They therefore reflect registered state.

## Timing

- All state updates on the rising edge of `ck`. Latency is one cycle from input sampling to `q`, `cnt` and `full`.
- `sin`, `pin`, `mode` and `en` are sampled at the edge and must be stable around it.
- Reset values, applied asynchronously while `res_n=0`:
  - `q = 0`, `cnt = 0`, `full = 0`
  - `sout_l = 0`, `sout_r = 0`
- Reset mid-operation: an in-progress frame is lost, the counter restarts from 0, and no partial state survives.
- Reset release: the first edge with `res_n=1` performs the selected mode normally. No dead cycle.
- `full` is not a handshake. It stays high until LOAD or CLR, and consumers sample `q` while `full=1`.

## Structure

- Package `shift_pkg` holds:
  - the `mode` localparams: `MODE_HOLD`, `MODE_SHL`, `MODE_SHR`, `MODE_LOAD`, `MODE_ROTL`, `MODE_ROTR`, `MODE_CLR`
  - a `shift_mode_t` 3-bit typedef
- Sub-module `shift_cnt` is natural. It is a saturating counter with parameter `MAX=W` and inputs `ck`, `res_n`, `inc`, `clr`, and outputs `cnt` and `full`.
  - `univ_shift_reg` drives `inc` = `en` and counted-shift mode.
  - It drives `clr` = `en` and LOAD-or-CLR mode.
- The data path is a single `always` block with a `case` on `mode`.

## Test plan

All scenarios use W=4 and `en=1` unless stated.

1. **Reset:** `res_n=0` asynchronously, mid-clock → `q=4'b0000`, `cnt=0`, `full=0` immediately, without waiting for a `ck` edge.
2. **SHL fill and saturate:** after CLR, SHL with `sin` = 1, 0, 1, 1 → `q=4'b1011`, `cnt=4`, `full=1` after the 4th edge. A 5th SHL with `sin=0` → `q=4'b0110`, `cnt` stays 4, `full` stays 1.
3. **LOAD then rotate:** LOAD `pin=4'b1001` → `q=4'b1001`, `cnt=0`, `full=0`. ROTR → `q=4'b1100`, `sout_r=0`. ROTL twice → `q=4'b0011`. `cnt` remains 0 throughout.
4. **SHR from zero:** SHR with `sin=1` twice → `q=4'b1100`, `cnt=2`, `sout_l=1`, `full=0`.
5. **Enable gating:** `en=0` with `mode=SHL`, `sin=1`, starting from `q=4'b0101`, held for 3 cycles → `q`, `cnt` and `full` unchanged. Reserved mode 7 with `en=1` → likewise unchanged.
6. **Reset mid-frame:** after 2 SHL, pulse `res_n` low between edges → `q=0` and `cnt=0` at once. The next SHL edge with `sin=1` → `q=4'b0001`, `cnt=1`.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared mode encoding for the universal shift register and its users.
package shift_pkg;

  typedef logic [2:0] shift_mode_t;

  localparam shift_mode_t MODE_HOLD = 3'd0;
  localparam shift_mode_t MODE_SHL  = 3'd1;
  localparam shift_mode_t MODE_SHR  = 3'd2;
  localparam shift_mode_t MODE_LOAD = 3'd3;
  localparam shift_mode_t MODE_ROTL = 3'd4;
  localparam shift_mode_t MODE_ROTR = 3'd5;
  localparam shift_mode_t MODE_CLR  = 3'd6;

endpackage

// File: rtl/shift_cnt.sv
// Saturating up-counter with a registered flag that is high while the count sits at MAX.
module shift_cnt #(
  parameter int MAX = 4,
  parameter int CW  = $clog2(MAX + 1)
) (
  input  logic          ck,
  input  logic          res_n,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          full
);

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ck or negedge res_n) begin
    if (!res_n) begin
      cnt  <= '0;
      full <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      full <= 1'b0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt  <= cnt + 1'b1;
      // Flag rises on the same edge the count reaches MAX, not one cycle later.
      full <= (cnt == CNT_MAX - 1'b1);
    end
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: shift left/right, rotate, parallel load, clear, with a saturating shift count.
module univ_shift_reg
  import shift_pkg::*;
#(
  parameter int W  = 4,
  parameter int CW = $clog2(W + 1)
) (
  input  logic          ck,
  input  logic          res_n,
  input  logic          en,
  input  logic [2:0]    mode,
  input  logic          sin,
  input  logic [W-1:0]  pin,
  output logic [W-1:0]  q,
  output logic          sout_l,
  output logic          sout_r,
  output logic [CW-1:0] cnt,
  output logic          full
);

  logic cnt_inc;
  logic cnt_clr;

  assign cnt_inc = en && ((mode == MODE_SHL) || (mode == MODE_SHR));
  assign cnt_clr = en && ((mode == MODE_LOAD) || (mode == MODE_CLR));

  always_ff @(posedge ck or negedge res_n) begin
    if (!res_n) begin
      q <= '0;
    end else if (en) begin
      case (mode)
        MODE_SHL:  q <= {q[W-2:0], sin};
        MODE_SHR:  q <= {sin, q[W-1:1]};
        MODE_LOAD: q <= pin;
        MODE_ROTL: q <= {q[W-2:0], q[W-1]};
        MODE_ROTR: q <= {q[0], q[W-1:1]};
        MODE_CLR:  q <= '0;
        default:   q <= q;  // HOLD and the reserved code
      endcase
    end
  end

  assign sout_l = q[W-1];
  assign sout_r = q[0];

  shift_cnt #(
    .MAX (W)
  ) u_cnt (
    .ck    (ck),
    .res_n (res_n),
    .inc   (cnt_inc),
    .clr   (cnt_clr),
    .cnt   (cnt),
    .full  (full)
  );

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg at W=4; expected values are hand-computed.
module tb_univ_shift_reg;
  import shift_pkg::*;

  localparam int W  = 4;
  localparam int CW = 3;

  logic          ck;
  logic          res_n;
  logic          en;
  logic [2:0]    mode;
  logic          sin;
  logic [W-1:0]  pin;
  logic [W-1:0]  q;
  logic          sout_l;
  logic          sout_r;
  logic [CW-1:0] cnt;
  logic          full;

  int total = 0;
  int bad   = 0;

  univ_shift_reg #(.W(W)) dut (
    .ck     (ck),
    .res_n  (res_n),
    .en     (en),
    .mode   (mode),
    .sin    (sin),
    .pin    (pin),
    .q      (q),
    .sout_l (sout_l),
    .sout_r (sout_r),
    .cnt    (cnt),
    .full   (full)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic step(input logic [2:0] m, input logic s, input logic [W-1:0] p);
    mode = m;
    sin  = s;
    pin  = p;
    @(posedge ck);
    #1;
  endtask

  task automatic test_reset();
    res_n = 1'b0; en = 1'b1; mode = MODE_HOLD; sin = 1'b0; pin = '0;
    #2;
    total++;
    if ({q, cnt, full, sout_l, sout_r} !== 10'b0) begin
      bad++;
      $display("FAIL reset_initial: q=%b cnt=%0d full=%b want 0000/0/0", q, cnt, full);
    end
    res_n = 1'b1;
    step(MODE_LOAD, 1'b0, 4'b1111);
    step(MODE_SHL, 1'b1, 4'b0000);
    // Mid-cycle assertion must clear everything without a clock edge.
    #2 res_n = 1'b0;
    #1;
    total++;
    if ({q, cnt, full, sout_l, sout_r} !== 10'b0) begin
      bad++;
      $display("FAIL reset_async: q=%b cnt=%0d full=%b sl=%b sr=%b want all 0", q, cnt, full, sout_l, sout_r);
    end
    #1 res_n = 1'b1;
  endtask

  task automatic test_shl_saturate();
    logic [4:0]   sin_v;
    logic [W-1:0] exp_q   [5];
    logic [CW-1:0] exp_c  [5];
    logic         exp_f   [5];
    sin_v = 5'b01101;  // applied LSB first: 1,0,1,1,0
    exp_q = '{4'b0001, 4'b0010, 4'b0101, 4'b1011, 4'b0110};
    exp_c = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    exp_f = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    step(MODE_CLR, 1'b0, '0);
    for (int i = 0; i < 5; i++) begin
      step(MODE_SHL, sin_v[i], '0);
      total++;
      if (q !== exp_q[i] || cnt !== exp_c[i] || full !== exp_f[i]) begin
        bad++;
        $display("FAIL shl_%0d: q=%b cnt=%0d full=%b want q=%b cnt=%0d full=%b",
                 i, q, cnt, full, exp_q[i], exp_c[i], exp_f[i]);
      end
    end
    // Rotation while saturated leaves the counter and flag alone.
    step(MODE_ROTL, 1'b0, '0);
    total++;
    if (q !== 4'b1100 || cnt !== 3'd4 || full !== 1'b1) begin
      bad++;
      $display("FAIL rotl_full: q=%b cnt=%0d full=%b want q=1100 cnt=4 full=1", q, cnt, full);
    end
  endtask

  task automatic test_load_rotate();
    logic [2:0]   m_v   [4];
    logic [W-1:0] exp_q [4];
    m_v   = '{MODE_LOAD, MODE_ROTR, MODE_ROTL, MODE_ROTL};
    exp_q = '{4'b1001, 4'b1100, 4'b1001, 4'b0011};
    for (int i = 0; i < 4; i++) begin
      step(m_v[i], 1'b1, 4'b1001);
      total++;
      if (q !== exp_q[i] || cnt !== 3'd0 || full !== 1'b0 || sout_r !== exp_q[i][0]) begin
        bad++;
        $display("FAIL load_rot_%0d: q=%b cnt=%0d full=%b sr=%b want q=%b cnt=0 full=0 sr=%b",
                 i, q, cnt, full, sout_r, exp_q[i], exp_q[i][0]);
      end
    end
  endtask

  task automatic test_shr();
    step(MODE_CLR, 1'b0, '0);
    step(MODE_SHR, 1'b1, '0);
    total++;
    if (q !== 4'b1000 || cnt !== 3'd1) begin
      bad++;
      $display("FAIL shr_1: q=%b cnt=%0d want q=1000 cnt=1", q, cnt);
    end
    step(MODE_SHR, 1'b1, '0);
    total++;
    if (q !== 4'b1100 || cnt !== 3'd2 || full !== 1'b0 || sout_l !== 1'b1 || sout_r !== 1'b0) begin
      bad++;
      $display("FAIL shr_2: q=%b cnt=%0d full=%b sl=%b sr=%b want q=1100 cnt=2 full=0 sl=1 sr=0",
               q, cnt, full, sout_l, sout_r);
    end
  endtask

  task automatic test_enable();
    logic [2:0] m_v [5];
    m_v = '{MODE_SHL, MODE_SHL, MODE_SHL, MODE_LOAD, MODE_CLR};
    step(MODE_CLR, 1'b0, '0);
    step(MODE_SHL, 1'b1, '0);
    step(MODE_SHL, 1'b0, '0);
    step(MODE_SHL, 1'b1, '0);
    total++;
    if (q !== 4'b0101 || cnt !== 3'd3) begin
      bad++;
      $display("FAIL en_setup: q=%b cnt=%0d want q=0101 cnt=3", q, cnt);
    end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(m_v[i], 1'b1, 4'b1110);
      total++;
      if (q !== 4'b0101 || cnt !== 3'd3 || full !== 1'b0) begin
        bad++;
        $display("FAIL en_low_%0d: q=%b cnt=%0d full=%b want q=0101 cnt=3 full=0", i, q, cnt, full);
      end
    end
    en = 1'b1;
    step(3'd7, 1'b1, 4'b1110);
    step(MODE_HOLD, 1'b1, 4'b1110);
    total++;
    if (q !== 4'b0101 || cnt !== 3'd3 || full !== 1'b0) begin
      bad++;
      $display("FAIL reserved_hold: q=%b cnt=%0d full=%b want q=0101 cnt=3 full=0", q, cnt, full);
    end
  endtask

  task automatic test_reset_mid_frame();
    step(MODE_CLR, 1'b0, '0);
    step(MODE_SHL, 1'b1, '0);
    step(MODE_SHL, 1'b1, '0);
    total++;
    if (q !== 4'b0011 || cnt !== 3'd2) begin
      bad++;
      $display("FAIL midframe_setup: q=%b cnt=%0d want q=0011 cnt=2", q, cnt);
    end
    #2 res_n = 1'b0;
    #1;
    total++;
    if (q !== 4'b0000 || cnt !== 3'd0 || full !== 1'b0) begin
      bad++;
      $display("FAIL midframe_reset: q=%b cnt=%0d full=%b want all 0", q, cnt, full);
    end
    #1 res_n = 1'b1;
    // First edge after release performs the shift with no dead cycle.
    step(MODE_SHL, 1'b1, '0);
    total++;
    if (q !== 4'b0001 || cnt !== 3'd1 || full !== 1'b0) begin
      bad++;
      $display("FAIL midframe_resume: q=%b cnt=%0d full=%b want q=0001 cnt=1 full=0", q, cnt, full);
    end
  endtask

  initial begin
    test_reset();
    test_shl_saturate();
    test_load_rotate();
    test_shr();
    test_enable();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
